// File: rtl/piso_tx_ctrl.sv
// Parallel-in serial-out transmitter with valid/ready intake, configurable bit order
// and a fixed inter-word idle gap. All serial-side outputs are registered.
module piso_tx_ctrl #(
    parameter int WIDTH     = 4,
    parameter int GAP       = 1,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             ser_out,
    output logic             ser_valid,
    output logic             frame_first,
    output logic             frame_last,
    output logic             busy
);

    localparam int CNT_W    = $clog2(WIDTH);
    localparam int GAP_W    = 4;
    localparam bit BACK2BACK = (GAP == 0);
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(WIDTH - 1);
    localparam logic [GAP_W-1:0] GAP_LAST = (GAP > 0) ? GAP_W'(GAP - 1) : '0;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SHIFT,
        ST_GAP
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   shift_reg;
    logic [CNT_W-1:0]   bit_cnt_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic               ser_out_reg;
    logic               ser_valid_reg;
    logic               frame_first_reg;
    logic               frame_last_reg;
    logic               busy_reg;

    logic [WIDTH-1:0]   in_ordered;
    logic               accept;

    // The shift register always shifts right; MSB-first words are reversed on load.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_order
            if (LSB_FIRST) begin : g_lsb
                assign in_ordered[gi] = in_data[gi];
            end else begin : g_msb
                assign in_ordered[gi] = in_data[WIDTH-1-gi];
            end
        end
    endgenerate

    assign in_ready = rst_n && !flush &&
                      ((state_reg == ST_IDLE) ||
                       (BACK2BACK && (state_reg == ST_SHIFT) && frame_last_reg));
    assign accept   = in_valid && in_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= ST_IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            gap_cnt_reg     <= '0;
            ser_out_reg     <= 1'b0;
            ser_valid_reg   <= 1'b0;
            frame_first_reg <= 1'b0;
            frame_last_reg  <= 1'b0;
            busy_reg        <= 1'b0;
        end else if (flush) begin
            state_reg       <= ST_IDLE;
            shift_reg       <= '0;
            bit_cnt_reg     <= '0;
            gap_cnt_reg     <= '0;
            ser_out_reg     <= 1'b0;
            ser_valid_reg   <= 1'b0;
            frame_first_reg <= 1'b0;
            frame_last_reg  <= 1'b0;
            busy_reg        <= 1'b0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (accept) begin
                        state_reg       <= ST_SHIFT;
                        shift_reg       <= in_ordered;
                        bit_cnt_reg     <= '0;
                        ser_out_reg     <= in_ordered[0];
                        ser_valid_reg   <= 1'b1;
                        frame_first_reg <= 1'b1;
                        frame_last_reg  <= 1'b0;
                        busy_reg        <= 1'b1;
                    end
                end

                ST_SHIFT: begin
                    if (bit_cnt_reg == LAST_IDX) begin
                        if (accept) begin
                            // Back-to-back word: reload without a dead cycle.
                            shift_reg       <= in_ordered;
                            bit_cnt_reg     <= '0;
                            ser_out_reg     <= in_ordered[0];
                            ser_valid_reg   <= 1'b1;
                            frame_first_reg <= 1'b1;
                            frame_last_reg  <= 1'b0;
                            busy_reg        <= 1'b1;
                        end else begin
                            state_reg       <= (GAP > 0) ? ST_GAP : ST_IDLE;
                            shift_reg       <= '0;
                            bit_cnt_reg     <= '0;
                            gap_cnt_reg     <= '0;
                            ser_out_reg     <= 1'b0;
                            ser_valid_reg   <= 1'b0;
                            frame_first_reg <= 1'b0;
                            frame_last_reg  <= 1'b0;
                            busy_reg        <= (GAP > 0);
                        end
                    end else begin
                        shift_reg       <= shift_reg >> 1;
                        bit_cnt_reg     <= bit_cnt_reg + CNT_W'(1);
                        ser_out_reg     <= shift_reg[1];
                        frame_first_reg <= 1'b0;
                        frame_last_reg  <= ((bit_cnt_reg + CNT_W'(1)) == LAST_IDX);
                    end
                end

                ST_GAP: begin
                    if (gap_cnt_reg == GAP_LAST) begin
                        state_reg   <= ST_IDLE;
                        gap_cnt_reg <= '0;
                        busy_reg    <= 1'b0;
                    end else begin
                        gap_cnt_reg <= gap_cnt_reg + GAP_W'(1);
                    end
                end

                default: begin
                    state_reg       <= ST_IDLE;
                    shift_reg       <= '0;
                    bit_cnt_reg     <= '0;
                    gap_cnt_reg     <= '0;
                    ser_out_reg     <= 1'b0;
                    ser_valid_reg   <= 1'b0;
                    frame_first_reg <= 1'b0;
                    frame_last_reg  <= 1'b0;
                    busy_reg        <= 1'b0;
                end
            endcase
        end
    end

    assign ser_out     = ser_out_reg;
    assign ser_valid   = ser_valid_reg;
    assign frame_first = frame_first_reg;
    assign frame_last  = frame_last_reg;
    assign busy        = busy_reg;

endmodule

// File: tb/tb_piso_tx_ctrl.sv
// Directed bench for piso_tx_ctrl: one table-driven run on the default build plus
// hand sequences for MSB-first, GAP=0 streaming, GAP=3 holdoff and mid-word reset.
module tb_piso_tx_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       flush = 1'b0;
    logic       in_valid = 1'b0;
    logic [3:0] in_data = 4'h0;

    int n_checks = 0;
    int n_errors = 0;

    // Per-DUT output bundles: {in_ready, ser_out, ser_valid, frame_first, frame_last, busy}
    logic [5:0] o_main, o_msb, o_g0, o_g3;
    logic rdy_m, so_m, sv_m, ff_m, fl_m, bz_m;
    logic rdy_b, so_b, sv_b, ff_b, fl_b, bz_b;
    logic rdy_z, so_z, sv_z, ff_z, fl_z, bz_z;
    logic rdy_t, so_t, sv_t, ff_t, fl_t, bz_t;

    assign o_main = {rdy_m, so_m, sv_m, ff_m, fl_m, bz_m};
    assign o_msb  = {rdy_b, so_b, sv_b, ff_b, fl_b, bz_b};
    assign o_g0   = {rdy_z, so_z, sv_z, ff_z, fl_z, bz_z};
    assign o_g3   = {rdy_t, so_t, sv_t, ff_t, fl_t, bz_t};

    always #5 clk = ~clk;

    piso_tx_ctrl #(.WIDTH(4), .GAP(1), .LSB_FIRST(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_m), .ser_out(so_m), .ser_valid(sv_m), .frame_first(ff_m),
        .frame_last(fl_m), .busy(bz_m));

    piso_tx_ctrl #(.WIDTH(4), .GAP(1), .LSB_FIRST(1'b0)) dut_msb (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_b), .ser_out(so_b), .ser_valid(sv_b), .frame_first(ff_b),
        .frame_last(fl_b), .busy(bz_b));

    piso_tx_ctrl #(.WIDTH(4), .GAP(0), .LSB_FIRST(1'b1)) dut_g0 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_z), .ser_out(so_z), .ser_valid(sv_z), .frame_first(ff_z),
        .frame_last(fl_z), .busy(bz_z));

    piso_tx_ctrl #(.WIDTH(4), .GAP(3), .LSB_FIRST(1'b1)) dut_g3 (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rdy_t), .ser_out(so_t), .ser_valid(sv_t), .frame_first(ff_t),
        .frame_last(fl_t), .busy(bz_t));

    typedef struct {
        logic       flush;
        logic       in_valid;
        logic [3:0] data;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[22];

    task automatic chk(input string name, input int idx, input logic [7:0] act,
                       input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s[%0d]: got %b expected %b", name, idx, act, exp);
        end
    endtask

    // Leaves the bench at posedge+1 with rst_n released; the next edge may accept.
    task automatic do_reset();
        rst_n    = 1'b0;
        flush    = 1'b0;
        in_valid = 1'b0;
        in_data  = 4'h0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: time limit reached, required $finish earlier");
        $fatal(1, "timeout");
    end

    initial begin : main_seq
        logic [3:0] msb_exp;
        logic [7:0] g0_stream;
        logic [3:0] rst_stream;

        // Columns: flush, in_valid, in_data, {ready, ser, valid, first, last, busy}
        tbl[0]  = '{1'b0, 1'b1, 4'hB, 6'b100000};
        tbl[1]  = '{1'b0, 1'b0, 4'h0, 6'b011101};
        tbl[2]  = '{1'b0, 1'b0, 4'h0, 6'b011001};
        tbl[3]  = '{1'b0, 1'b0, 4'h0, 6'b001001};
        tbl[4]  = '{1'b0, 1'b0, 4'h0, 6'b011011};
        tbl[5]  = '{1'b0, 1'b0, 4'h0, 6'b000001};
        tbl[6]  = '{1'b0, 1'b1, 4'h6, 6'b100000};
        tbl[7]  = '{1'b0, 1'b0, 4'h0, 6'b001101};
        tbl[8]  = '{1'b0, 1'b0, 4'h0, 6'b011001};
        tbl[9]  = '{1'b0, 1'b0, 4'h0, 6'b011001};
        tbl[10] = '{1'b0, 1'b0, 4'h0, 6'b001011};
        tbl[11] = '{1'b0, 1'b0, 4'h0, 6'b000001};
        tbl[12] = '{1'b0, 1'b1, 4'hF, 6'b100000};
        tbl[13] = '{1'b0, 1'b1, 4'hF, 6'b011101};
        tbl[14] = '{1'b0, 1'b1, 4'hF, 6'b011001};
        tbl[15] = '{1'b1, 1'b1, 4'hF, 6'b011001};
        tbl[16] = '{1'b1, 1'b1, 4'hF, 6'b000000};
        tbl[17] = '{1'b1, 1'b1, 4'hF, 6'b000000};
        tbl[18] = '{1'b0, 1'b0, 4'h0, 6'b100000};
        tbl[19] = '{1'b0, 1'b1, 4'h2, 6'b100000};
        tbl[20] = '{1'b0, 1'b0, 4'h0, 6'b001101};
        tbl[21] = '{1'b0, 1'b0, 4'h0, 6'b011001};

        // Asynchronous reset takes effect with no clock edge.
        #1 rst_n = 1'b0;
        #1;
        chk("rst_main", 0, {2'b0, o_main}, 8'h00);
        chk("rst_msb",  0, {2'b0, o_msb},  8'h00);
        chk("rst_g0",   0, {2'b0, o_g0},   8'h00);
        chk("rst_g3",   0, {2'b0, o_g3},   8'h00);

        // Table run on the default build (GAP=1, LSB first).
        do_reset();
        for (int i = 0; i < 22; i++) begin
            flush    = tbl[i].flush;
            in_valid = tbl[i].in_valid;
            in_data  = tbl[i].data;
            @(negedge clk);
            chk("vec", i, {2'b0, o_main}, {2'b0, tbl[i].exp});
            $display("vec %0d: flush=%b valid=%b data=%h out=%b", i, tbl[i].flush,
                     tbl[i].in_valid, tbl[i].data, o_main);
            next_cycle();
        end
        flush = 1'b0;

        // MSB-first: 4'b1011 -> 1,0,1,1
        do_reset();
        msb_exp  = 4'b1101;
        in_valid = 1'b1;
        in_data  = 4'hB;
        @(negedge clk);
        chk("msb_ready", 0, {7'b0, rdy_b}, 8'h01);
        next_cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("msb_bit", k, {4'b0, so_b, sv_b, ff_b, fl_b},
                {4'b0, msb_exp[k], 1'b1, (k == 0), (k == 3)});
            $display("msb bit %0d: ser_out=%b", k, so_b);
            next_cycle();
        end

        // GAP=0 streaming: A then 5 back-to-back, 8 contiguous bits.
        do_reset();
        g0_stream = 8'b01011010;
        in_valid  = 1'b1;
        in_data   = 4'hA;
        @(negedge clk);
        chk("g0_ready0", 0, {7'b0, rdy_z}, 8'h01);
        next_cycle();
        in_data = 4'h5;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("g0_bit", k, {3'b0, rdy_z, so_z, sv_z, ff_z, fl_z},
                {3'b0, (k == 3 || k == 7), g0_stream[k], 1'b1, (k == 0 || k == 4),
                 (k == 3 || k == 7)});
            $display("g0 bit %0d: ser_out=%b ready=%b", k, so_z, rdy_z);
            next_cycle();
            if (k == 3) in_valid = 1'b0;
        end
        @(negedge clk);
        chk("g0_idle", 0, {6'b0, rdy_z, sv_z}, 8'b10);
        next_cycle();

        // GAP=3: in_valid held through shift and gap, accepted on first IDLE edge.
        do_reset();
        in_valid = 1'b1;
        in_data  = 4'h0;
        @(negedge clk);
        chk("g3_ready0", 0, {7'b0, rdy_t}, 8'h01);
        next_cycle();
        in_data = 4'h9;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("g3_hold", k, {5'b0, rdy_t, sv_t, bz_t}, {5'b0, 1'b0, (k < 4), 1'b1});
            $display("g3 cycle %0d: ready=%b valid=%b busy=%b", k, rdy_t, sv_t, bz_t);
            next_cycle();
        end
        @(negedge clk);
        chk("g3_idle_ready", 0, {6'b0, rdy_t, bz_t}, 8'b10);
        next_cycle();
        in_valid = 1'b0;
        @(negedge clk);
        chk("g3_accept", 0, {5'b0, so_t, sv_t, ff_t}, 8'b111);
        next_cycle();

        // Reset pulsed mid-clock during bit 1, then word 3 -> 1,1,0,0.
        do_reset();
        rst_stream = 4'b0011;
        in_valid   = 1'b1;
        in_data    = 4'hF;
        next_cycle();
        in_valid = 1'b0;
        next_cycle();
        #1;
        chk("rst_pre", 0, {6'b0, sv_m, bz_m}, 8'b11);
        in_valid = 1'b1;
        in_data  = 4'h3;
        rst_n    = 1'b0;
        #1;
        chk("rst_mid", 0, {2'b0, o_main}, 8'h00);
        $display("mid-clock reset: outputs=%b", o_main);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("rst_release", 0, {2'b0, o_main}, 8'b00100000);
        next_cycle();
        in_valid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("rst_word", k, {6'b0, so_m, sv_m}, {6'b0, rst_stream[k], 1'b1});
            $display("post-reset bit %0d: ser_out=%b", k, so_m);
            next_cycle();
        end
        @(negedge clk);
        chk("rst_gap", 0, {6'b0, sv_m, bz_m}, 8'b01);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
